serial_to_par: RTL and testbench

//  Serial-to-parallel receiver; sits directly downstream of the byte serializer on the PHY link.

---
 rtl/serial_to_par_pkg.sv | 17 +
 rtl/serial_to_par.sv | 112 +++++++++++
 tb/tb_serial_to_par.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_to_par_pkg.sv
// Shared PHY definitions: idle/alignment comma, receiver state encoding, field widths.
package serial_to_par_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BIT_CNT_W   = 3;
  localparam int unsigned COMMA_CNT_W = 4;

  // Idle symbol the serializer sends when it has no valid data.
  localparam logic [BYTE_W-1:0] PHY_COMMA = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_e;

endpackage : serial_to_par_pkg

// File: rtl/serial_to_par.sv
// Serial-to-parallel receiver: comma-based byte alignment, then one valid
// strobe per received non-comma byte.
module serial_to_par
  import serial_to_par_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA      = PHY_COMMA,
  parameter int unsigned       COMMA_LOCK = 4
) (
  input  logic              clk_8f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
);

  localparam logic [COMMA_CNT_W-1:0] LOCK_CNT = COMMA_CNT_W'(COMMA_LOCK);

  rx_state_e              state_q, state_d;
  // Only the seven most recent bits are kept; the window supplies the eighth.
  logic [BYTE_W-2:0]      shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [COMMA_CNT_W-1:0] comma_cnt_q, comma_cnt_d;
  logic [BYTE_W-1:0]      data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   active_q, active_d;

  logic [BYTE_W-1:0]      window;
  logic                   is_comma;
  logic                   boundary;

  assign window   = {shift_q, data_in};
  assign is_comma = (window == COMMA);
  assign boundary = (bit_cnt_q == BIT_CNT_W'(7));

  // State and datapath registers; reset is asynchronous and may hit mid-byte.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
    end
  end

  // Alignment FSM: bit-sliding hunt, aligned comma counting, then data capture.
  always_comb begin
    state_d     = state_q;
    shift_d     = window[BYTE_W-2:0];
    bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
    comma_cnt_d = comma_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    active_d    = active_q;

    unique case (state_q)
      SEARCH: begin
        if (is_comma) begin
          bit_cnt_d   = '0;
          comma_cnt_d = COMMA_CNT_W'(1);
          if (LOCK_CNT == COMMA_CNT_W'(1)) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = LOCKING;
          end
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + COMMA_CNT_W'(1);
            if (comma_cnt_d == LOCK_CNT) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            // A broken comma run restarts the hunt from the next bit.
            state_d     = SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        // Commas are idle fill and are silently dropped.
        if (boundary && !is_comma) begin
          data_d  = window;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule : serial_to_par

// File: tb/tb_serial_to_par.sv
// Directed bench for serial_to_par: byte vectors with expected strobe/data/active.
module tb_serial_to_par;

  logic       clk_8f = 1'b0;
  logic       reset  = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  typedef struct {
    logic [7:0] pat;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_active;
  } vec_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] cur_data   = 8'h00;
  logic       cur_active = 1'b0;

  serial_to_par #(.COMMA(8'hBC), .COMMA_LOCK(4)) dut (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one bit at the falling edge; return 1 time unit after the rising edge that samples it.
  task automatic send_bit(input logic b);
    @(negedge clk_8f);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " valid"},  8'(valid_out), 8'h00);
    check({tag, " active"}, 8'(active),    8'h00);
    check({tag, " data"},   data_out,      cur_data);
  endtask

  // Send one byte MSB first; outputs must hold for bits 7..1 and update on the LSB edge.
  task automatic play(input vec_t v, input string tag);
    for (int i = 7; i >= 1; i--) begin
      send_bit(v.pat[i]);
      check({tag, " mid valid"},  8'(valid_out), 8'h00);
      check({tag, " mid data"},   data_out,      cur_data);
      check({tag, " mid active"}, 8'(active),    8'(cur_active));
    end
    send_bit(v.pat[0]);
    check({tag, " valid"},  8'(valid_out), 8'(v.exp_valid));
    check({tag, " data"},   data_out,      v.exp_data);
    check({tag, " active"}, 8'(active),    8'(v.exp_active));
    cur_data   = v.exp_data;
    cur_active = v.exp_active;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk_8f);
    data_in = 1'b0;
    reset   = 1'b1;
    repeat (cycles) @(negedge clk_8f);
    reset      = 1'b0;
    cur_data   = 8'h00;
    cur_active = 1'b0;
  endtask

  vec_t main_tbl[10];
  vec_t false_tbl[7];
  vec_t relock_tbl[6];

  initial begin
    // Lock on four commas, then 5A / comma / 3C, then back-to-back FF 00 A5.
    main_tbl[0] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    main_tbl[1] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    main_tbl[2] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    main_tbl[3] = '{8'hBC, 1'b0, 8'h00, 1'b1};
    main_tbl[4] = '{8'h5A, 1'b1, 8'h5A, 1'b1};
    main_tbl[5] = '{8'hBC, 1'b0, 8'h5A, 1'b1};
    main_tbl[6] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
    main_tbl[7] = '{8'hFF, 1'b1, 8'hFF, 1'b1};
    main_tbl[8] = '{8'h00, 1'b1, 8'h00, 1'b1};
    main_tbl[9] = '{8'hA5, 1'b1, 8'hA5, 1'b1};

    // Two commas then a broken run, then a clean re-lock and one data byte.
    false_tbl[0] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    false_tbl[1] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    false_tbl[2] = '{8'h12, 1'b0, 8'h00, 1'b0};
    false_tbl[3] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    false_tbl[4] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    false_tbl[5] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    false_tbl[6] = '{8'hBC, 1'b0, 8'h00, 1'b1};

    // After a mid-stream reset: data is ignored until four aligned commas.
    relock_tbl[0] = '{8'h33, 1'b0, 8'h00, 1'b0};
    relock_tbl[1] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    relock_tbl[2] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    relock_tbl[3] = '{8'hBC, 1'b0, 8'h00, 1'b0};
    relock_tbl[4] = '{8'hBC, 1'b0, 8'h00, 1'b1};
    relock_tbl[5] = '{8'h66, 1'b1, 8'h66, 1'b1};

    // Reset held with random serial data.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_8f);
      data_in = 1'($urandom);
      @(posedge clk_8f);
      #1;
      check_idle("reset");
    end
    @(negedge clk_8f);
    data_in = 1'b0;
    reset   = 1'b0;

    // Three junk bits ahead of the first comma.
    send_bit(1'b1); check_idle("junk0");
    send_bit(1'b1); check_idle("junk1");
    send_bit(1'b0); check_idle("junk2");

    for (int i = 0; i < 10; i++) play(main_tbl[i], $sformatf("main[%0d]", i));

    do_reset(2);
    for (int i = 0; i < 7; i++) play(false_tbl[i], $sformatf("false[%0d]", i));
    play('{8'h77, 1'b1, 8'h77, 1'b1}, "relock data");

    // Mid-stream reset while bit 4 of a data byte is on the wire.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk_8f);
    data_in = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async rst data",   data_out,      8'h00);
    check("async rst valid",  8'(valid_out), 8'h00);
    check("async rst active", 8'(active),    8'h00);
    repeat (2) @(negedge clk_8f);
    reset      = 1'b0;
    cur_data   = 8'h00;
    cur_active = 1'b0;
    for (int i = 0; i < 6; i++) play(relock_tbl[i], $sformatf("relock[%0d]", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_to_par
